// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and address helpers for the dual-port byte-enabled RAM
package ram_pkg;

  typedef enum logic [1:0] {
    RamLat1 = 2'd1,
    RamLat2 = 2'd2
  } ram_lat_e;

  // Response record at the default 32-bit word width.
  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } ram_rsp_t;

  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Out of range above the array, or not word aligned.
  function automatic logic addr_err(input logic [31:0] addr, input int lsb, input int aw);
    logic [63:0] a;
    logic [63:0] lim;
    logic [63:0] lmask;
    a     = {32'd0, addr};
    lim   = 64'd1 << (lsb + aw);
    lmask = (64'd1 << lsb) - 64'd1;
    return (a >= lim) || ((a & lmask) != 64'd0);
  endfunction

endpackage

// File: rtl/ram_rsp_pipe.sv
// rtl/ram_rsp_pipe.sv - ReadLatency-deep response delay line; rdata only moves with rvalid
module ram_rsp_pipe
  import ram_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  input  logic                 err_i,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 rvalid_o,
  output logic                 err_o,
  output logic [DataWidth-1:0] rdata_o
);

  logic [ReadLatency-1:0] valid_q;
  logic [ReadLatency-1:0] err_q;
  logic [DataWidth-1:0]   data_q  [ReadLatency];

  logic [ReadLatency:0]   valid_d;
  logic [ReadLatency:0]   err_d;
  logic [DataWidth-1:0]   data_d  [ReadLatency+1];

  assign valid_d = {valid_q, valid_i};
  assign err_d   = {err_q, err_i};

  always_comb begin
    data_d[0] = rdata_i;
    for (int i = 0; i < ReadLatency; i++) begin
      data_d[i+1] = data_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      err_q   <= '0;
      for (int i = 0; i < ReadLatency; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d[ReadLatency-1:0];
      err_q   <= err_d[ReadLatency-1:0] & valid_d[ReadLatency-1:0];
      // Data stages hold while idle so rdata_o keeps the last response.
      for (int i = 0; i < ReadLatency; i++) begin
        if (valid_d[i]) begin
          data_q[i] <= data_d[i];
        end
      end
    end
  end

  assign rvalid_o = valid_d[ReadLatency];
  assign err_o    = err_d[ReadLatency];
  assign rdata_o  = data_d[ReadLatency];

endmodule

// File: rtl/ram_2p_be.sv
// rtl/ram_2p_be.sv - true dual-port byte-enabled read-first RAM; RAM_ADDR_CHECK_EN adds err ports
module ram_2p_be
  import ram_pkg::*;
#(
  parameter int DataWidth   = 32,
  parameter int Depth       = 2048,
  parameter int ReadLatency = 1,
  parameter bit WritePrioA  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   a_req_i,
  input  logic                   a_we_i,
  input  logic [DataWidth/8-1:0] a_be_i,
  input  logic [31:0]            a_addr_i,
  input  logic [DataWidth-1:0]   a_wdata_i,
  output logic                   a_rvalid_o,
  output logic [DataWidth-1:0]   a_rdata_o,
  input  logic                   b_req_i,
  input  logic                   b_we_i,
  input  logic [DataWidth/8-1:0] b_be_i,
  input  logic [31:0]            b_addr_i,
  input  logic [DataWidth-1:0]   b_wdata_i,
  output logic                   b_rvalid_o,
  output logic [DataWidth-1:0]   b_rdata_o
`ifdef RAM_ADDR_CHECK_EN
  ,
  output logic                   a_err_o,
  output logic                   b_err_o
`endif
);

  localparam int AddrLsb  = addr_lsb(DataWidth);
  localparam int Aw       = addr_w(Depth);
  localparam int NumBytes = DataWidth / 8;

  if (ReadLatency != int'(RamLat1) && ReadLatency != int'(RamLat2)) begin : g_bad_lat
    $fatal(1, "ram_2p_be: ReadLatency must be 1 or 2");
  end
  if (DataWidth < 8 || (DataWidth % 8) != 0) begin : g_bad_dw
    $fatal(1, "ram_2p_be: DataWidth must be a multiple of 8, at least 8");
  end
  if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $fatal(1, "ram_2p_be: Depth must be a power of two, at least 2");
  end

  logic [DataWidth-1:0] mem_q [Depth];

  logic [Aw-1:0] a_idx, b_idx;
  logic          a_err, b_err;
  logic          a_acc, b_acc;
  logic          a_wr, b_wr;
  logic          unused_addr;

  assign a_idx = a_addr_i[AddrLsb+Aw-1:AddrLsb];
  assign b_idx = b_addr_i[AddrLsb+Aw-1:AddrLsb];
  assign unused_addr = ^{a_addr_i, b_addr_i};

`ifdef RAM_ADDR_CHECK_EN
  assign a_err = addr_err(a_addr_i, AddrLsb, Aw);
  assign b_err = addr_err(b_addr_i, AddrLsb, Aw);
`else
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  assign a_acc = a_req_i & ~rst_i;
  assign b_acc = b_req_i & ~rst_i;
  assign a_wr  = a_acc & a_we_i & ~a_err;
  assign b_wr  = b_acc & b_we_i & ~b_err;

  // The "hi" port is applied last, so it owns any byte both ports enable.
  logic                 lo_wr, hi_wr;
  logic [NumBytes-1:0]  lo_be, hi_be;
  logic [Aw-1:0]        lo_idx, hi_idx;
  logic [DataWidth-1:0] lo_wdata, hi_wdata;

  if (WritePrioA) begin : g_prio_a
    assign {lo_wr, lo_be, lo_idx, lo_wdata} = {b_wr, b_be_i, b_idx, b_wdata_i};
    assign {hi_wr, hi_be, hi_idx, hi_wdata} = {a_wr, a_be_i, a_idx, a_wdata_i};
  end else begin : g_prio_b
    assign {lo_wr, lo_be, lo_idx, lo_wdata} = {a_wr, a_be_i, a_idx, a_wdata_i};
    assign {hi_wr, hi_be, hi_idx, hi_wdata} = {b_wr, b_be_i, b_idx, b_wdata_i};
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NumBytes; k++) begin
      if (lo_wr && lo_be[k]) begin
        mem_q[lo_idx][8*k +: 8] <= lo_wdata[8*k +: 8];
      end
    end
    for (int k = 0; k < NumBytes; k++) begin
      if (hi_wr && hi_be[k]) begin
        mem_q[hi_idx][8*k +: 8] <= hi_wdata[8*k +: 8];
      end
    end
  end

  // Combinational read sees pre-edge contents: read-first for both ports.
  logic [DataWidth-1:0] a_rd, b_rd;
  assign a_rd = a_err ? '0 : mem_q[a_idx];
  assign b_rd = b_err ? '0 : mem_q[b_idx];

  logic a_err_rsp, b_err_rsp;

  ram_rsp_pipe #(.DataWidth(DataWidth), .ReadLatency(ReadLatency)) u_pipe_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (a_acc),
    .err_i   (a_err),
    .rdata_i (a_rd),
    .rvalid_o(a_rvalid_o),
    .err_o   (a_err_rsp),
    .rdata_o (a_rdata_o)
  );

  ram_rsp_pipe #(.DataWidth(DataWidth), .ReadLatency(ReadLatency)) u_pipe_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (b_acc),
    .err_i   (b_err),
    .rdata_i (b_rd),
    .rvalid_o(b_rvalid_o),
    .err_o   (b_err_rsp),
    .rdata_o (b_rdata_o)
  );

`ifdef RAM_ADDR_CHECK_EN
  assign a_err_o = a_err_rsp;
  assign b_err_o = b_err_rsp;
`else
  logic unused_err;
  assign unused_err = a_err_rsp ^ b_err_rsp;
`endif

endmodule

// File: tb/tb_ram_2p_be.sv
// tb/tb_ram_2p_be.sv - table-driven scoreboard bench for ram_2p_be (latency 1/prio A and latency 2/prio B)
module tb_ram_2p_be;

  typedef struct {
    logic        a_req, a_we;
    logic [3:0]  a_be;
    logic [31:0] a_addr, a_wdata;
    logic        b_req, b_we;
    logic [3:0]  b_be;
    logic [31:0] b_addr, b_wdata;
    logic        chk_a, chk_b, err_a, err_b;
    logic [31:0] exp_a1, exp_b1, exp_a0, exp_b0;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        chk;
    logic        err;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [3:0]  a_be = 0, b_be = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;

  logic        rv [4];
  logic [31:0] rd [4];
  logic        er [4];

  always #5 clk = ~clk;

  ram_2p_be #(.DataWidth(32), .Depth(2048), .ReadLatency(1), .WritePrioA(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rvalid_o(rv[0]), .a_rdata_o(rd[0]),
    .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rvalid_o(rv[1]), .b_rdata_o(rd[1])
`ifdef RAM_ADDR_CHECK_EN
    , .a_err_o(er[0]), .b_err_o(er[1])
`endif
  );

  ram_2p_be #(.DataWidth(32), .Depth(2048), .ReadLatency(2), .WritePrioA(1'b0)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .a_req_i(a_req), .a_we_i(a_we), .a_be_i(a_be), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rvalid_o(rv[2]), .a_rdata_o(rd[2]),
    .b_req_i(b_req), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rvalid_o(rv[3]), .b_rdata_o(rd[3])
`ifdef RAM_ADDR_CHECK_EN
    , .a_err_o(er[2]), .b_err_o(er[3])
`endif
  );

`ifndef RAM_ADDR_CHECK_EN
  initial begin
    for (int i = 0; i < 4; i++) er[i] = 1'b0;
  end
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit mon_en = 0;
  exp_t q [4][$];
  logic [31:0] last [4];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int ch);
    exp_t e;
    if (rv[ch]) begin
      n_cmp++;
      if (q[ch].size() == 0) begin
        n_bad++;
        $display("FAIL spurious_rvalid ch%0d: got rvalid 1 expected 0 at cycle %0d", ch, cyc);
      end else begin
        e = q[ch].pop_front();
        if (e.due != cyc) begin
          n_bad++;
          $display("FAIL latency ch%0d: got cycle %0d expected %0d", ch, cyc, e.due);
        end
        if (e.chk) check($sformatf("rdata ch%0d cyc%0d", ch, cyc), rd[ch], e.data);
`ifdef RAM_ADDR_CHECK_EN
        check($sformatf("err ch%0d cyc%0d", ch, cyc), {31'd0, er[ch]}, {31'd0, e.err});
`endif
      end
      last[ch] = rd[ch];
    end else begin
      if (q[ch].size() != 0 && q[ch][0].due <= cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_rvalid ch%0d: got rvalid 0 expected 1 at cycle %0d", ch, cyc);
        void'(q[ch].pop_front());
      end
      check($sformatf("rdata_hold ch%0d cyc%0d", ch, cyc), rd[ch], last[ch]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int ch = 0; ch < 4; ch++) mon(ch);
    end
  end

  function automatic vec_t mk(input logic ar, input logic aw, input logic [3:0] abe,
                              input logic [31:0] aad, input logic [31:0] awd,
                              input logic br, input logic bw, input logic [3:0] bbe,
                              input logic [31:0] bad, input logic [31:0] bwd,
                              input logic ca, input logic cb,
                              input logic [31:0] ea1, input logic [31:0] eb1,
                              input logic [31:0] ea0, input logic [31:0] eb0);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_be = abe; v.a_addr = aad; v.a_wdata = awd;
    v.b_req = br; v.b_we = bw; v.b_be = bbe; v.b_addr = bad; v.b_wdata = bwd;
    v.chk_a = ca; v.chk_b = cb; v.err_a = 1'b0; v.err_b = 1'b0;
    v.exp_a1 = ea1; v.exp_b1 = eb1; v.exp_a0 = ea0; v.exp_b0 = eb0;
    return v;
  endfunction

  task automatic push(input int ch, input logic [31:0] d, input logic c, input logic e, input int due);
    exp_t x;
    x.data = d; x.chk = c; x.err = e; x.due = due;
    q[ch].push_back(x);
  endtask

  task automatic apply(input vec_t v);
    a_req = v.a_req; a_we = v.a_we; a_be = v.a_be; a_addr = v.a_addr; a_wdata = v.a_wdata;
    b_req = v.b_req; b_we = v.b_we; b_be = v.b_be; b_addr = v.b_addr; b_wdata = v.b_wdata;
  endtask

  task automatic drive(input vec_t v);
    @(posedge clk);
    #2;
    apply(v);
    if (v.a_req) begin
      push(0, v.exp_a1, v.chk_a, v.err_a, cyc + 1);
      push(2, v.exp_a0, v.chk_a, v.err_a, cyc + 2);
    end
    if (v.b_req) begin
      push(1, v.exp_b1, v.chk_b, v.err_b, cyc + 1);
      push(3, v.exp_b0, v.chk_b, v.err_b, cyc + 2);
    end
  endtask

  vec_t tbl [15];
  vec_t idle;
  vec_t v;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle = mk(0,0,4'h0,32'h0,32'h0, 0,0,4'h0,32'h0,32'h0, 0,0, 0,0,0,0);
    tbl[0]  = mk(1,1,4'hF,32'h10,32'hDEADBEEF, 1,1,4'hF,32'h20,32'h11223344, 0,0, 0,0,0,0);
    tbl[1]  = mk(1,0,4'h0,32'h10,32'h0, 1,1,4'h5,32'h20,32'hAABBCCDD, 1,1,
                 32'hDEADBEEF,32'h11223344,32'hDEADBEEF,32'h11223344);
    tbl[2]  = mk(1,1,4'hF,32'h40,32'h0, 1,0,4'h0,32'h20,32'h0, 0,1, 0,32'h11BB33DD,0,32'h11BB33DD);
    tbl[3]  = mk(1,1,4'hF,32'h40,32'hAAAAAAAA, 1,1,4'h3,32'h40,32'hBBBBBBBB, 1,1, 0,0,0,0);
    tbl[4]  = mk(1,0,4'h0,32'h40,32'h0, 1,0,4'h0,32'h40,32'h0, 1,1,
                 32'hAAAAAAAA,32'hAAAAAAAA,32'hAAAABBBB,32'hAAAABBBB);
    tbl[5]  = mk(1,1,4'hF,32'h80,32'h1, 0,0,4'h0,32'h0,32'h0, 0,0, 0,0,0,0);
    tbl[6]  = mk(1,1,4'hF,32'h80,32'h2, 1,0,4'h0,32'h80,32'h0, 1,1, 32'h1,32'h1,32'h1,32'h1);
    tbl[7]  = mk(1,0,4'h0,32'h80,32'h0, 1,0,4'h0,32'h10,32'h0, 1,1,
                 32'h2,32'hDEADBEEF,32'h2,32'hDEADBEEF);
    tbl[8]  = mk(1,1,4'h0,32'h10,32'h0, 0,0,4'h0,32'h0,32'h0, 1,0, 32'hDEADBEEF,0,32'hDEADBEEF,0);
    tbl[9]  = idle;
    tbl[10] = mk(1,0,4'h0,32'h10,32'h0, 1,1,4'hF,32'h1FFC,32'hCAFEF00D, 1,0,
                 32'hDEADBEEF,0,32'hDEADBEEF,0);
    tbl[11] = mk(1,1,4'hF,32'h0,32'h12345678, 1,0,4'h0,32'h1FFC,32'h0, 0,1,
                 0,32'hCAFEF00D,0,32'hCAFEF00D);
    tbl[12] = mk(1,0,4'h0,32'h0,32'h0, 1,0,4'h0,32'h1FFC,32'h0, 1,1,
                 32'h12345678,32'hCAFEF00D,32'h12345678,32'hCAFEF00D);
    tbl[13] = idle;
    tbl[14] = idle;

    repeat (3) @(posedge clk);
    #2;
    for (int ch = 0; ch < 4; ch++) begin
      check($sformatf("reset_rvalid ch%0d", ch), {31'd0, rv[ch]}, 32'd0);
      check($sformatf("reset_rdata ch%0d", ch), rd[ch], 32'd0);
      last[ch] = 32'd0;
    end
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 15; i++) drive(tbl[i]);

    // Reset with reads in flight; a write presented during reset must be dropped.
    drive(mk(1,0,4'h0,32'h10,32'h0, 1,0,4'h0,32'h80,32'h0, 1,1,
             32'hDEADBEEF,32'h2,32'hDEADBEEF,32'h2));
    @(posedge clk);
    #2;
    rst = 1'b1;
    apply(mk(1,1,4'hF,32'h10,32'h0, 1,1,4'hF,32'h80,32'hFFFFFFFF, 0,0, 0,0,0,0));
    for (int ch = 0; ch < 4; ch++) begin
      while (q[ch].size() > 0 && q[ch][$].due > cyc) void'(q[ch].pop_back());
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    apply(idle);
    for (int ch = 0; ch < 4; ch++) begin
      check($sformatf("midreset_rvalid ch%0d", ch), {31'd0, rv[ch]}, 32'd0);
      check($sformatf("midreset_rdata ch%0d", ch), rd[ch], 32'd0);
      last[ch] = 32'd0;
    end
    drive(mk(1,0,4'h0,32'h10,32'h0, 1,0,4'h0,32'h80,32'h0, 1,1,
             32'hDEADBEEF,32'h2,32'hDEADBEEF,32'h2));
    drive(idle);

`ifdef RAM_ADDR_CHECK_EN
    v = mk(1,1,4'hF,32'h2000,32'hFFFFFFFF, 0,0,4'h0,32'h0,32'h0, 1,0, 0,0,0,0);
    v.err_a = 1'b1;
    drive(v);
    v = mk(1,0,4'h0,32'h0,32'h0, 1,0,4'h0,32'h2,32'h0, 1,1, 32'h12345678,0,32'h12345678,0);
    v.err_b = 1'b1;
    drive(v);
    drive(idle);
`else
    v = idle;
    drive(v);
`endif

    repeat (4) drive(idle);
    for (int ch = 0; ch < 4; ch++) check($sformatf("drain ch%0d", ch), q[ch].size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_2p_be.md
Name: ram_2p_be

Overview:
- Parametrised, true dual-port, byte-enabled synchronous RAM; successor to the fixed 32-bit, 2048-word single-port memory.
- Two independent request ports (A: instruction/ROM side, B: data/LSU side) share one storage array on one clock.
- Configurable word width, depth and read latency (1 or 2 cycles).
- Sits between the Ibex bus host/arbiter and the on-chip memory map; replaces per-use RAM/ROM copies such as the enlarged sbox table.

Parameters:
- DataWidth, 32, word width in bits; multiple of 8, at least 8.
- Depth, 2048, number of words; power of two, at least 2.
- ReadLatency, 1, cycles from accepted req to rvalid; legal values 1 or 2.
- WritePrioA, 1, on a same-word write collision: 1 = port A wins, 0 = port B wins.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- a_req_i  in  1  port A request.
- a_we_i  in  1  port A write enable.
- a_be_i  in  DataWidth/8  port A byte enables.
- a_addr_i  in  32  port A byte address.
- a_wdata_i  in  DataWidth  port A write data.
- a_rvalid_o  out  1  port A response valid.
- a_rdata_o  out  DataWidth  port A read data.
- b_req_i, b_we_i, b_be_i, b_addr_i, b_wdata_i, b_rvalid_o, b_rdata_o: identical to port A, for port B.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Addressing:
  - AddrLsb = clog2(DataWidth/8); Aw = clog2(Depth).
  - Word index = addr[AddrLsb+Aw-1:AddrLsb].
  - Upper and LSB address bits are ignored (aliasing) unless the optional feature is compiled in.
- Request acceptance: every req_i=1 cycle is accepted. There is no stall and no gnt.
- Write:
  - On req&we, byte lane k of the indexed word takes wdata[8k+7:8k] iff be[k]=1.
  - be=0 makes the write a no-op but still produces a response.
- Read-first:
  - rdata for any accepted request (read or write) is the word content before that cycle's writes, from either port.
- Response timing:
  - rvalid_o is asserted exactly ReadLatency cycles after each accepted req, for one cycle per request.
  - Back-to-back requests give back-to-back rvalid.
- ReadLatency=2: adds an output register stage on rvalid and rdata. Throughput is still one request per cycle per port.
- Data hold: rdata_o holds its last value when no response is pending. It is only updated on a cycle where rvalid_o is asserted.
- Collisions:
  - Both ports write the same word in the same cycle: for each byte enabled on both ports, the WritePrioA winner's data is stored. Bytes enabled on only one port are written by that port.
  - Read on one port and write on the other to the same word: the read returns the old data.
- Reset:
  - rst_i=1 forces all rvalid pipeline stages to 0 and all rdata_o registers to 0 on the next edge.
  - Responses in flight are discarded. Memory contents are not reset.
  - Requests presented while rst_i=1 are ignored: no write, no response.
- Parameter check: an illegal ReadLatency or DataWidth triggers a simulation $fatal at elaboration.

Optional Feature:
- Macro: RAM_ADDR_CHECK_EN.
- Defined:
  - Adds a_err_o and b_err_o (1 bit each; reset 0).
  - A request is in error if any address bit above AddrLsb+Aw-1 is set, or addr[AddrLsb-1:0] is not zero.
  - An errored request suppresses its write and returns rdata=0.
  - err_o is asserted in the same cycle as that request's rvalid_o.
- Undefined: the err ports are absent, aliasing applies, and all writes proceed.

Decomposition:
- Package ram_pkg:
  - Localparam functions for AddrLsb and Aw.
  - Enum ram_lat_e {RamLat1=1, RamLat2=2}.
  - Typedef ram_rsp_t {rvalid, err, rdata}.
- Sub-module ram_rsp_pipe:
  - Parametrised delay line (ReadLatency stages) for rvalid/err/rdata with synchronous reset.
  - One instance per port.
- The storage array and collision merge stay in the top module.

Test Plan:
- Latency: ReadLatency=1. Write A addr 0x10 wdata 0xDEADBEEF be 0xF, then read A 0x10 → rvalid one cycle after the read req, rdata=0xDEADBEEF. Repeat with ReadLatency=2 → rvalid two cycles after.
- Byte enables: word 0x20 preloaded to 0x11223344. Write B be 0x5 wdata 0xAABBCCDD → subsequent read returns 0x11BB33DD.
- Write collision: A and B both write 0x40 in the same cycle, A=0xAAAAAAAA be 0xF, B=0xBBBBBBBB be 0x3, WritePrioA=1 → read returns 0xAAAAAAAA. With WritePrioA=0 → read returns 0xAAAABBBB.
- Read-first: word 0x80 holds 0x1. A writes 0x2 while B reads 0x80 in the same cycle → B rdata=0x1; a read in the next cycle returns 0x2.
- Reset mid-flight: ReadLatency=2, issue reads on both ports, assert rst_i for one cycle in between → no rvalid emerges, rdata_o=0, memory contents still intact afterwards.
- RAM_ADDR_CHECK_EN with Depth=2048: write to 0x2000 → err asserted with rvalid, rdata=0, and word 0x0 unchanged. Read 0x0002 → err=1.
